// File: rtl/alu_req_responder_if.sv
// Bundle of the request, ALU-port and response channels of alu_req_responder.
// slave = the responder side, master = initiator plus ALU.
interface alu_req_responder_if #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 4,
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [SEL_W-1:0] req_sel;
  logic [TAG_W-1:0] req_tag;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [SEL_W-1:0] alu_sel;
  logic [WIDTH-1:0] alu_out;
  logic             alu_carry;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carry;
  logic [TAG_W-1:0] rsp_tag;

  logic             busy;

  modport slave (
    input  req_valid, req_a, req_b, req_sel, req_tag,
    output req_ready,
    output alu_a, alu_b, alu_sel,
    input  alu_out, alu_carry,
    output rsp_valid, rsp_result, rsp_carry, rsp_tag,
    input  rsp_ready,
    output busy
  );

  modport master (
    output req_valid, req_a, req_b, req_sel, req_tag,
    input  req_ready,
    input  alu_a, alu_b, alu_sel,
    output alu_out, alu_carry,
    input  rsp_valid, rsp_result, rsp_carry, rsp_tag,
    output rsp_ready,
    input  busy
  );
endinterface

// File: rtl/alu_req_responder.sv
// Clocked front end for the combinational ALU: one op per three cycles, tagged
// results queued in a FWFT FIFO. Define ALU_RSP_STATS_EN for push/carry counters.
module alu_req_responder #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 4,
  parameter int TAG_W = 4,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_req_responder_if.slave   bus
`ifdef ALU_RSP_STATS_EN
  ,
  input  logic                 stat_clr_i,
  output logic [15:0]          stat_ops_o,
  output logic [15:0]          stat_carry_o
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [SEL_W-1:0] alu_sel_q;
  logic [TAG_W-1:0] tag_q;
  logic             busy_q;

  logic             req_ready;
  logic             req_fire;
  logic             push;
  logic             pop;
  logic             rsp_valid;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [WIDTH-1:0] mem_result [DEPTH];
  logic             mem_carry  [DEPTH];
  logic [TAG_W-1:0] mem_tag    [DEPTH];

  // Only IDLE accepts, and only with a free slot, so a capture can never overflow.
  always_comb begin
    req_ready = rst_n && (state_q == IDLE) && (count_q < CNT_W'(DEPTH));
    req_fire  = req_ready && bus.req_valid;
    push      = (state_q == CAPTURE);
    rsp_valid = (count_q != '0);
    pop       = rsp_valid && bus.rsp_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      tag_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_fire) begin
            state_q   <= SETTLE;
            alu_a_q   <= bus.req_a;
            alu_b_q   <= bus.req_b;
            alu_sel_q <= bus.req_sel;
            tag_q     <= bus.req_tag;
            busy_q    <= 1'b1;
          end
        end
        SETTLE: begin
          state_q <= CAPTURE;
          busy_q  <= 1'b1;
        end
        CAPTURE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_result[wr_ptr_q] <= bus.alu_out;
      mem_carry[wr_ptr_q]  <= bus.alu_carry;
      mem_tag[wr_ptr_q]    <= tag_q;
    end
  end

  always_comb begin
    bus.req_ready  = req_ready;
    bus.alu_a      = alu_a_q;
    bus.alu_b      = alu_b_q;
    bus.alu_sel    = alu_sel_q;
    bus.busy       = busy_q;
    bus.rsp_valid  = rsp_valid;
    bus.rsp_result = rsp_valid ? mem_result[rd_ptr_q] : '0;
    bus.rsp_carry  = rsp_valid ? mem_carry[rd_ptr_q]  : 1'b0;
    bus.rsp_tag    = rsp_valid ? mem_tag[rd_ptr_q]    : '0;
  end

`ifdef ALU_RSP_STATS_EN
  logic [15:0] stat_ops_q;
  logic [15:0] stat_carry_q;

  // Clear wins over counting; both counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops_q   <= '0;
      stat_carry_q <= '0;
    end else if (stat_clr_i) begin
      stat_ops_q   <= '0;
      stat_carry_q <= '0;
    end else if (push) begin
      if (stat_ops_q != 16'hFFFF) stat_ops_q <= stat_ops_q + 16'd1;
      if (bus.alu_carry && (stat_carry_q != 16'hFFFF)) stat_carry_q <= stat_carry_q + 16'd1;
    end
  end

  assign stat_ops_o   = stat_ops_q;
  assign stat_carry_o = stat_carry_q;
`endif

endmodule

// File: doc/alu_req_responder.md
Name: alu_req_responder

Overview:
- Clocked responder that fronts the combinational 8-bit ALU. It accepts operation requests over a valid/ready channel and drives the registered operands and select onto the ALU ports.
- After a fixed settle cycle it samples ALU_Out/CarryOut and returns tagged results through a response FIFO with its own valid/ready channel.
- Sits between a sequential initiator (CPU stub or bench driver) and the `alu` instance. It is the receiving end of the operation stream the bench otherwise drives directly.

Parameters:
- WIDTH, 8, operand/result width; matches the ALU A, B and ALU_Out.
- SEL_W, 4, ALU_Sel width.
- TAG_W, 4, width of the opaque request tag returned with each response.
- DEPTH, 4, response FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at a clk edge.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- req_sel  in  SEL_W  ALU operation select.
- req_tag  in  TAG_W  request tag.
- alu_a  out  WIDTH  to ALU A; registered.
- alu_b  out  WIDTH  to ALU B; registered.
- alu_sel  out  SEL_W  to ALU ALU_Sel; registered.
- alu_out  in  WIDTH  from ALU ALU_Out.
- alu_carry  in  1  from ALU CarryOut.
- rsp_valid  out  1  FIFO head valid.
- rsp_ready  in  1  consumer accepts head.
- rsp_result  out  WIDTH  captured alu_out.
- rsp_carry  out  1  captured alu_carry.
- rsp_tag  out  TAG_W  tag of originating request.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE.
  - alu_a, alu_b, alu_sel = 0.
  - FIFO is emptied: rsp_valid = 0; rsp_result, rsp_carry, rsp_tag = 0.
  - busy = 0; req_ready = 0 while rst_n is low.
- FSM states: IDLE, SETTLE, CAPTURE.
  - IDLE -> SETTLE on request accept. At that edge, req_a/req_b/req_sel are loaded into alu_a/alu_b/alu_sel and req_tag into an internal tag register.
  - SETTLE -> CAPTURE unconditionally. This is one full cycle for the ALU combinational path to settle.
  - CAPTURE -> IDLE unconditionally. At that edge {alu_out, alu_carry, tag} is pushed into the FIFO.
- req_ready = rst_n && state==IDLE && fifo_count < DEPTH.
  - A request accepted in IDLE always has a free slot, so no overflow is possible.
- Latency: request accepted at edge E0 -> push at edge E2 -> rsp_valid high after E2 if the FIFO was empty.
  - Earliest next accept is edge E3, giving 1 request per 3 cycles maximum.
- alu_a/alu_b/alu_sel hold their last values in IDLE; they are not cleared after an operation.
- FIFO behaviour:
  - First-word fall-through: rsp_* present the head entry whenever rsp_valid = 1.
  - Pop on rsp_valid && rsp_ready.
  - Simultaneous push and pop: count unchanged, data order preserved.
  - Pointers wrap modulo DEPTH.
  - When count == DEPTH, req_ready = 0 until a pop occurs.
  - rsp_* must stay stable while rsp_valid && !rsp_ready.
- rsp_result/rsp_carry are the raw ALU values; no width extension or modification.
- busy = (state != IDLE).
- Reset mid-operation (SETTLE/CAPTURE): the in-flight op is dropped and no response is produced. Queued responses are also lost.
- req_* inputs are ignored when req_ready = 0, even if req_valid = 1.

Optional Feature:
- Macro: ALU_RSP_STATS_EN.
- Defined:
  - Adds outputs stat_ops (16-bit) and stat_carry (16-bit), both reset to 0.
  - stat_ops increments on every FIFO push.
  - stat_carry increments on a push whose alu_carry = 1.
  - Both counters saturate at 16'hFFFF.
  - Adds input stat_clr (1-bit), synchronous; it zeroes both counters and takes priority over increment.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset check: rst_n low for 3 cycles -> rsp_valid = 0, req_ready = 0, alu_a/alu_b/alu_sel = 0, busy = 0. After release -> req_ready = 1.
- Single add: req A=8'hF0, B=8'h20, sel=4'b0000, tag=3 accepted at E0 -> alu_a/alu_b/alu_sel = F0/20/0 after E0, busy high for 2 cycles. rsp_valid after E2 with result=8'h10, carry=1, tag=3.
- Select 4'b1110 with A=8'h05, B=8'h03 -> response result equals the ALU ALU_Out for that select (8'h01), and the tag is returned unchanged.
- Backpressure/full: rsp_ready = 0, issue 5 back-to-back requests -> exactly 4 accepted, then req_ready = 0. Release rsp_ready -> 4 responses in issue order (tags 0,1,2,3), the 5th request is then accepted, and a stalled head stays stable.
- Simultaneous push/pop: count = DEPTH-1 with push at the same edge as pop -> count stays DEPTH-1, no entry lost, ordering intact.
- Reset in SETTLE: assert rst_n low one cycle after accept -> no response ever appears, FIFO empty, and the next request behaves normally. With ALU_RSP_STATS_EN: 3 ops, 2 with carry -> stat_ops = 3, stat_carry = 2; stat_clr -> both 0.
